uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel UART receiver; the inbound counterpart of the free-running baud generator and transmitter path. It recovers bit timing from each start-bit falling edge using an internal bit-period counter, samples bits at mid-period, and presents bytes to the RX FIFO over a valid/ready handshake. Errors are flagged as single-cycle pulses.

## Interface
- CLK_FREQ, 50000000: system clock frequency, Hz.
- BAUD_RATE, 1000000: line bit rate, bits/s.
- DATA_BITS, 8: data bits per frame, 5..8.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- rx  in  1  serial line, asynchronous to clk, idles high.
- data  out  DATA_BITS  received byte, LSB = first bit on the line; stable while valid.
- valid  out  1  byte available; held until accepted.
- ready  in  1  consumer (FIFO) accepts when valid && ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun_err  out  1  one-cycle pulse: new byte completed while valid still high.
- parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 without parity).

## Operation
- BAUD_TICKS = CLK_FREQ/BAUD_RATE (integer division); HALF_TICKS = BAUD_TICKS/2. Elaboration error if BAUD_TICKS < 4.
- rx passes through a 2-flop synchronizer (reset value 1); FSM uses synchronized rx_s only.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: rx_s == 0 -> START, counter cleared.
- START: at counter == HALF_TICKS-1 sample rx_s; 1 -> IDLE (glitch, no flags); 0 -> DATA, counter and bit index cleared.
- DATA: at counter == BAUD_TICKS-1 shift rx_s in LSB-first, counter cleared; after DATA_BITS samples -> PARITY or STOP.
- STOP: at counter == BAUD_TICKS-1 sample rx_s. 1: data <= shift register, valid <= 1, -> IDLE. 0: frame_err pulse, no valid, data unchanged, -> BREAK.
- BREAK: wait for rx_s == 1, then -> IDLE (a held-low line never yields spurious frames).
- Handshake: valid clears on the cycle after valid && ready. A completing frame with valid already high: data overwritten, valid stays 1, overrun_err pulses; a simultaneous ready in that cycle accepts the old byte and no overrun is flagged.
- Counter width $clog2(BAUD_TICKS); counter wraps to 0 at every sample point, never free-runs outside START/DATA/PARITY/STOP.
- Reset (any time, mid-frame included): state IDLE, counter 0, shift register 0, data 0, valid 0, all error outputs 0, synchronizer flops 1.

## Timing
- Pin-to-rx_s latency: 2 cycles.
- Let cycle 0 be the first cycle rx_s == 0 in IDLE. Start sample at cycle HALF_TICKS; data bit k sample at HALF_TICKS + (k+1)*BAUD_TICKS; stop sample at HALF_TICKS + (DATA_BITS+1)*BAUD_TICKS (+BAUD_TICKS with parity).
- Defaults: start check at 25, stop sample at 475; valid/frame_err/overrun_err high from cycle 476 (registered at the stop-sample edge).
- Back-to-back frames: return to IDLE at stop mid-bit leaves half a bit to catch the next start edge; no dead cycles required.
- Error pulses last exactly one cycle.

## Configuration
- UART_RX_PARITY_EN defined: one even-parity bit follows data; PARITY state samples it at counter == BAUD_TICKS-1; mismatch pulses parity_err in the same cycle as valid (byte still delivered).
- Undefined: no PARITY state, frame is start + DATA_BITS + stop, parity_err tied 0.

## Structure
- Shared uart_pkg: rx state enum, baud_ticks(CLK_FREQ, BAUD_RATE) function, IDLE_LEVEL constant; same package used by baud generator and transmitter.
- One sub-module: sync_2ff (2-flop synchronizer, parameterized reset value).

## Test plan
- Defaults, ready=1, send 0xA5 (8N1, 50 clk/bit) -> valid one cycle at ~476 after start detect, data = 0xA5, no errors.
- 0x00 then 0xFF back-to-back, no idle gap -> two valids, data 0x00 then 0xFF.
- rx low for 10 cycles then high -> no valid, no error, FSM back in IDLE by cycle 26.
- 0x3C with stop bit low, rx held low 200 cycles then high -> frame_err one pulse, no valid; next frame 0x11 received correctly.
- ready=0, send 0x12 then 0x34 -> overrun_err at second completion, data = 0x34, valid held; ready=1 -> valid drops next cycle.
- Reset asserted mid-DATA of 0x55, released, send 0x66 -> all outputs 0 during reset, only 0x66 delivered; with UART_RX_PARITY_EN, 0x01 with parity bit 0 -> parity_err pulse with valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisor helper
// and the idle line level, used by the baud generator, transmitter and receiver.
package uart_pkg;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    function automatic int baud_ticks(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clk, reset (async, active-high), d (async in), q (synchronized out).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, valid/ready output, one-cycle error pulses.
// Ports: clk, reset (async, active-high), rx (serial in), data/valid/ready
// (byte handshake), frame_err, overrun_err, parity_err.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 1000000,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int BAUD_TICKS = baud_ticks(CLK_FREQ, BAUD_RATE);
    localparam int HALF_TICKS = BAUD_TICKS / 2;
    localparam int CW = $clog2(BAUD_TICKS);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_TICKS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    if (BAUD_TICKS < 4) begin : g_check
        $error("uart_rx: BAUD_TICKS must be at least 4");
    end

    logic rx_s;

    sync_2ff #(.RESET_VAL(IDLE_LEVEL)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n;
    logic                 fe_n, oe_n;
    logic                 cnt_end;

    assign cnt_end = (cnt == CNT_FULL);

`ifdef UART_RX_PARITY_EN
    logic perr, perr_n, pe_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            perr       <= perr_n;
            parity_err <= pe_n;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RX_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            data        <= '0;
            valid       <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shift       <= shift_n;
            data        <= data_n;
            valid       <= valid_n;
            frame_err   <= fe_n;
            overrun_err <= oe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        data_n  = data;
        valid_n = valid;
        fe_n    = 1'b0;
        oe_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n  = perr;
        pe_n    = 1'b0;
`endif
        if (valid && ready) valid_n = 1'b0;

        unique case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_n = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_end) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[DATA_BITS-1:1]};
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = RX_PARITY;
`else
                        state_n = RX_STOP;
`endif
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (cnt_end) begin
                    cnt_n   = '0;
                    perr_n  = ^{shift, rx_s};
                    state_n = RX_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`else
                cnt_n   = '0;
                state_n = RX_IDLE;
`endif
            end
            RX_STOP: begin
                if (cnt_end) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        // Old byte taken this same cycle: not an overrun.
                        oe_n    = valid && !ready;
`ifdef UART_RX_PARITY_EN
                        pe_n    = perr;
`endif
                        state_n = RX_IDLE;
                    end else begin
                        fe_n    = 1'b1;
                        state_n = RX_BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = RX_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = RX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at default parameters (50 clk/bit, 8 bits).
// Define UART_RX_PARITY_EN to exercise the even-parity build.
module tb_uart_rx;

    localparam int BT = 50;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 528;
`else
    localparam int LAT = 478;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    uart_rx #(
        .CLK_FREQ  (50000000),
        .BAUD_RATE (1000000),
        .DATA_BITS (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_acc = 0;
    int         n_fe = 0;
    int         n_oe = 0;
    int         n_pe = 0;
    int         n_pe_v = 0;
    int         last_rise = -1;
    logic       v_d = 1'b0;
    logic [7:0] acc_q[$];

    always @(negedge clk) begin
        if (valid && ready) begin
            n_acc++;
            acc_q.push_back(data);
        end
        if (frame_err) n_fe++;
        if (overrun_err) n_oe++;
        if (parity_err) n_pe++;
        if (parity_err && valid) n_pe_v++;
        if (valid && !v_d) last_rise = cyc;
        v_d = valid;
    end

    int pass = 0;
    int total = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        idle(BT);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic bad_par);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_out((^b) ^ bad_par);
`else
        if (bad_par) rx = 1'b1;
`endif
        bit_out(stop);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         exp_acc;
        int         exp_fe;
    } vec_t;

    vec_t vt[6];
    int   b_acc, b_fe, b_oe, b_q, t0;

    task automatic snap();
        b_acc = n_acc;
        b_fe  = n_fe;
        b_oe  = n_oe;
        b_q   = acc_q.size();
    endtask

    initial begin
        vt[0] = '{8'hA5, 1'b1, 1, 0};
        vt[1] = '{8'h00, 1'b1, 1, 0};
        vt[2] = '{8'hFF, 1'b1, 1, 0};
        vt[3] = '{8'h5A, 1'b1, 1, 0};
        vt[4] = '{8'h3C, 1'b0, 0, 1};
        vt[5] = '{8'h11, 1'b1, 1, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_errs", {29'd0, frame_err, overrun_err, parity_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(10);

        for (int i = 0; i < 6; i++) begin
            snap();
            t0 = cyc;
            send_frame(vt[i].b, vt[i].stop, 1'b0);
            if (!vt[i].stop) begin
                rx = 1'b0;
                idle(200);
                rx = 1'b1;
            end
            idle(60);
            check($sformatf("v%0d_acc", i), n_acc - b_acc, vt[i].exp_acc);
            check($sformatf("v%0d_fe", i), n_fe - b_fe, vt[i].exp_fe);
            check($sformatf("v%0d_oe", i), n_oe - b_oe, 32'd0);
            if (vt[i].exp_acc == 1 && acc_q.size() > b_q)
                check($sformatf("v%0d_data", i), {24'd0, acc_q[b_q]},
                      {24'd0, vt[i].b});
            if (i == 0)
                check("latency", last_rise - t0, LAT);
        end

        snap();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(60);
        check("b2b_acc", n_acc - b_acc, 32'd2);
        if (acc_q.size() >= b_q + 2) begin
            check("b2b_d0", {24'd0, acc_q[b_q]}, 32'h00);
            check("b2b_d1", {24'd0, acc_q[b_q+1]}, 32'hFF);
        end

        snap();
        rx = 1'b0;
        idle(10);
        rx = 1'b1;
        idle(20);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(60);
        check("glitch_acc", n_acc - b_acc, 32'd1);
        check("glitch_fe", n_fe - b_fe, 32'd0);
        if (acc_q.size() > b_q)
            check("glitch_data", {24'd0, acc_q[b_q]}, 32'hC3);

        ready = 1'b0;
        snap();
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        idle(30);
        @(negedge clk);
        check("ovr_oe", n_oe - b_oe, 32'd1);
        check("ovr_valid", {31'd0, valid}, 32'd1);
        check("ovr_data", {24'd0, data}, 32'h34);
        @(posedge clk);
        #1 ready = 1'b1;
        @(negedge clk);
        check("ovr_hold", {31'd0, valid}, 32'd1);
        @(negedge clk);
        check("ovr_drop", {31'd0, valid}, 32'd0);
        idle(5);

        snap();
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                repeat (200) @(posedge clk);
                #1 reset = 1'b1;
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("mid_rst_valid", {31'd0, valid}, 32'd0);
                check("mid_rst_data", {24'd0, data}, 32'd0);
                check("mid_rst_errs",
                      {29'd0, frame_err, overrun_err, parity_err}, 32'd0);
            end
        join
        @(posedge clk);
        #1 reset = 1'b0;
        idle(20);
        send_frame(8'h66, 1'b1, 1'b0);
        idle(60);
        check("rst_acc", n_acc - b_acc, 32'd1);
        if (acc_q.size() > b_q)
            check("rst_data66", {24'd0, acc_q[b_q]}, 32'h66);

`ifdef UART_RX_PARITY_EN
        check("par_none", n_pe, 32'd0);
        snap();
        send_frame(8'h01, 1'b1, 1'b1);
        idle(60);
        check("par_pe", n_pe, 32'd1);
        check("par_pe_valid", n_pe_v, 32'd1);
        check("par_acc", n_acc - b_acc, 32'd1);
        if (acc_q.size() > b_q)
            check("par_data", {24'd0, acc_q[b_q]}, 32'h01);
`else
        check("par_tied", n_pe, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
